ntt_butterfly_ctrl: RTL

Sequencer for the single radix-2 butterfly PE (14-bit datapath, `sel`=0 Cooley-Tukey NTT, `sel`=1 Gentleman-Sande INTT with halving).
- Steps through all stages of an in-place length-N transform, one butterfly per cycle.
- Drives the coefficient RAM read/write addresses and the twiddle ROM address.
- Delays write-back addresses to match the PE pipeline.
- Drains the pipeline between stages so no stage reads data that is still in flight.

---
 rtl/ntt_pkg.sv | 18 +
 rtl/ntt_addr_gen.sv | 30 +++
 rtl/ntt_butterfly_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ntt_pkg.sv
// ntt_pkg: shared FSM state, mode encoding and default sizing for the NTT butterfly sequencer
package ntt_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic MODE_NTT  = 1'b0;
    localparam logic MODE_INTT = 1'b1;

    localparam int DEF_N_LOG    = 8;
    localparam int DEF_NTT_LAT  = 6;
    localparam int DEF_INTT_LAT = 7;

endpackage

// File: rtl/ntt_addr_gen.sv
// ntt_addr_gen: operand and twiddle addresses for butterfly j of stage s (NTT or INTT)
module ntt_addr_gen
    import ntt_pkg::*;
#(
    parameter int N_LOG = DEF_N_LOG,
    parameter int SW    = (N_LOG > 1) ? $clog2(N_LOG) : 1
) (
    input  logic [SW-1:0]    s_i,
    input  logic [N_LOG-1:0] j_i,
    input  logic             mode_i,
    output logic [N_LOG-1:0] addr_u_o,
    output logic [N_LOG-1:0] addr_v_o,
    output logic [N_LOG:0]   tw_addr_o
);

    logic [N_LOG-1:0] sh, len, g, k, base;

    // Both modes share one form: sh = log2(len); the twiddle base is 1 << (N_LOG-1-sh)
    always_comb begin
        sh        = (mode_i == MODE_INTT) ? N_LOG'(s_i) : N_LOG'(N_LOG - 1) - N_LOG'(s_i);
        len       = N_LOG'(1) << sh;
        g         = j_i >> sh;
        k         = j_i & (len - N_LOG'(1));
        base      = N_LOG'(1) << (N_LOG'(N_LOG - 1) - sh);
        addr_u_o  = (g << (sh + N_LOG'(1))) | k;
        addr_v_o  = addr_u_o + len;
        tw_addr_o = {mode_i, base + g};
    end

endmodule

// File: rtl/ntt_butterfly_ctrl.sv
// ntt_butterfly_ctrl: radix-2 NTT/INTT butterfly sequencer; NTT_CTRL_STALL_EN adds a stall input
module ntt_butterfly_ctrl
    import ntt_pkg::*;
#(
    parameter int N_LOG    = DEF_N_LOG,
    parameter int NTT_LAT  = DEF_NTT_LAT,
    parameter int INTT_LAT = DEF_INTT_LAT
) (
    input  logic             clk,
    input  logic             rst,
`ifdef NTT_CTRL_STALL_EN
    input  logic             stall,
`endif
    input  logic             start,
    input  logic             mode,
    output logic             busy,
    output logic             done,
    output logic             sel,
    output logic             rd_en,
    output logic [N_LOG-1:0] rd_addr_u,
    output logic [N_LOG-1:0] rd_addr_v,
    output logic [N_LOG:0]   tw_addr,
    output logic             wr_en,
    output logic [N_LOG-1:0] wr_addr_u,
    output logic [N_LOG-1:0] wr_addr_v
);

    localparam int MAX_LAT = (NTT_LAT > INTT_LAT) ? NTT_LAT : INTT_LAT;
    localparam int SW      = (N_LOG > 1) ? $clog2(N_LOG) : 1;
    localparam int CW      = $clog2(MAX_LAT + 1);
    localparam logic [N_LOG-1:0] J_LAST = N_LOG'((1 << (N_LOG - 1)) - 1);
    localparam logic [SW-1:0]    S_LAST = SW'(N_LOG - 1);

    typedef struct packed {
        logic             v;
        logic [N_LOG-1:0] u;
        logic [N_LOG-1:0] w;
    } wb_t;

    state_e           state_q, state_d;
    logic [SW-1:0]    s_q, s_d;
    logic [N_LOG-1:0] j_q, j_d;
    logic [CW-1:0]    cnt_q, cnt_d, lat;
    logic             sel_q, sel_d, stl;
    logic [N_LOG-1:0] au, av;
    logic [N_LOG:0]   tw;
    wb_t              sr_q [MAX_LAT+1];

`ifdef NTT_CTRL_STALL_EN
    assign stl = stall;
`else
    assign stl = 1'b0;
`endif

    ntt_addr_gen #(.N_LOG(N_LOG), .SW(SW)) u_addr_gen (
        .s_i      (s_q),
        .j_i      (j_q),
        .mode_i   (sel_q),
        .addr_u_o (au),
        .addr_v_o (av),
        .tw_addr_o(tw)
    );

    assign lat       = (sel_q == MODE_INTT) ? CW'(INTT_LAT) : CW'(NTT_LAT);
    assign rd_en     = (state_q == S_RUN) && !stl;
    assign rd_addr_u = rd_en ? au : '0;
    assign rd_addr_v = rd_en ? av : '0;
    assign tw_addr   = rd_en ? tw : '0;
    assign busy      = state_q != S_IDLE;
    assign done      = state_q == S_DONE;
    assign sel       = sel_q;
    assign wr_en     = sr_q[lat].v;
    assign wr_addr_u = sr_q[lat].u;
    assign wr_addr_v = sr_q[lat].w;

    // DRAIN is entered the cycle after the last issue; cnt_q == lat marks that issue's write
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        j_d     = j_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_RUN;
                sel_d   = mode;
                s_d     = '0;
                j_d     = '0;
            end
            S_RUN: if (rd_en) begin
                j_d     = (j_q == J_LAST) ? '0 : j_q + N_LOG'(1);
                state_d = (j_q == J_LAST) ? S_DRAIN : S_RUN;
                cnt_d   = '0;
            end
            S_DRAIN: begin
                cnt_d   = cnt_q + CW'(1);
                state_d = (cnt_q != lat) ? S_DRAIN : (s_q == S_LAST) ? S_DONE : S_RUN;
                s_d     = (cnt_q == lat && s_q != S_LAST) ? s_q + SW'(1) : s_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            s_q     <= '0;
            j_q     <= '0;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            for (int i = 0; i <= MAX_LAT; i++) sr_q[i] <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            j_q     <= j_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            sr_q[0] <= '{v: rd_en, u: rd_addr_u, w: rd_addr_v};
            for (int i = 1; i <= MAX_LAT; i++) sr_q[i] <= sr_q[i-1];
        end
    end

endmodule
